// File: rtl/fifo_burst_reader.sv
// Read-side burst controller for fifo_sync: pulls a fixed number of words out of the FIFO and
// streams them downstream through a 2-entry skid buffer that absorbs the FIFO read latency.
module fifo_burst_reader #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned LEN_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             abort_i,
    input  logic             empty_i,
    input  logic [WIDTH-1:0] rdata_i,
    output logic             r_en_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [LEN_W-1:0] count_o
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] issue_q, issue_d;
    logic [LEN_W-1:0] count_q, count_d;
    logic             inflight_q, inflight_d;
    logic [WIDTH-1:0] buf_q [2];
    logic [WIDTH-1:0] buf_d [2];
    logic             head_q, head_d;
    logic [1:0]       occ_q, occ_d;

    logic             pop;
    logic             r_en;
    logic             active;
    logic [1:0]       occ_after_pop;

    always_comb begin
        active        = (state_q == StRun) || (state_q == StDrain);
        pop           = (occ_q != 2'd0) && out_ready_i;
        occ_after_pop = occ_q - {1'b0, pop};
        // Credit counts the slot freed by this cycle's pop so streaming keeps one word per cycle.
        r_en = (state_q == StRun) && !abort_i && !empty_i && (issue_q < len_q) &&
               ((occ_after_pop + {1'b0, inflight_q}) < 2'd2);

        state_d    = state_q;
        len_d      = len_q;
        issue_d    = issue_q;
        count_d    = count_q;
        inflight_d = r_en;
        buf_d      = buf_q;
        head_d     = head_q;
        occ_d      = occ_q + {1'b0, inflight_q} - {1'b0, pop};

        // Word read last cycle lands at the tail; credit rules keep occ_q <= 1 here.
        if (inflight_q) begin
            buf_d[head_q ^ occ_q[0]] = rdata_i;
        end
        if (pop) begin
            head_d = ~head_q;
            if (count_q < len_q) begin
                count_d = count_q + 1'b1;
            end
        end
        if (r_en) begin
            issue_d = issue_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (start_i && !abort_i) begin
                    len_d   = len_i;
                    issue_d = '0;
                    count_d = '0;
                    state_d = (len_i == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (issue_d == len_q) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (count_d == len_q) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Abort drops buffered and in-flight words; the delivered count is kept.
        if (abort_i && active) begin
            state_d    = StIdle;
            occ_d      = 2'd0;
            inflight_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            len_q      <= '0;
            issue_q    <= '0;
            count_q    <= '0;
            inflight_q <= 1'b0;
            buf_q      <= '{default: '0};
            head_q     <= 1'b0;
            occ_q      <= 2'd0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            issue_q    <= issue_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            buf_q      <= buf_d;
            head_q     <= head_d;
            occ_q      <= occ_d;
        end
    end

    assign r_en_o      = r_en;
    assign out_valid_o = (occ_q != 2'd0);
    assign out_data_o  = buf_q[head_q];
    assign busy_o      = active;
    assign done_o      = (state_q == StDone);
    assign count_o     = count_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a behavioural fifo_sync read port model.
module tb_fifo_burst_reader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] len;
    logic       abort;
    logic       empty;
    logic [3:0] rdata;
    logic       r_en;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic       busy;
    logic       done;
    logic [7:0] count;

    int checks = 0;
    int errors = 0;

    // FIFO model: registered read data, written by the stimulus, popped on r_en.
    logic [3:0] fifo_mem [0:63];
    logic [7:0] wr_ptr = '0;
    logic [7:0] rd_ptr = '0;
    logic       fifo_flush = 1'b0;

    assign empty = (wr_ptr == rd_ptr);

    initial rdata = 4'h0;
    always @(posedge clk) begin
        if (fifo_flush) begin
            rd_ptr <= wr_ptr;
        end else if (r_en) begin
            rdata  <= fifo_mem[rd_ptr[5:0]];
            rd_ptr <= rd_ptr + 8'd1;
        end
    end

    always #5 clk = ~clk;

    fifo_burst_reader #(
        .WIDTH(4),
        .LEN_W(8)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (start),
        .len_i      (len),
        .abort_i    (abort),
        .empty_i    (empty),
        .rdata_i    (rdata),
        .r_en_o     (r_en),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_data_o (out_data),
        .busy_o     (busy),
        .done_o     (done),
        .count_o    (count)
    );

    // Per-run monitor state
    logic [3:0] got [0:15];
    int n_got, done_cnt, done_at, last_xfer, ren_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [3:0] w);
        fifo_mem[wr_ptr[5:0]] = w;
        wr_ptr = wr_ptr + 8'd1;
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_mon();
        n_got = 0; done_cnt = 0; done_at = -1; last_xfer = -1; ren_cnt = 0;
    endtask

    // Runs ncyc cycles with a repeating ready pattern, an optional spurious start and optional
    // timed FIFO writes (one word every push_period cycles), recording every transfer.
    task automatic run(input int ncyc, input logic [7:0] rdy_pat, input int spur_at,
                       input int push_period, input int push_n, input logic [3:0] push_base);
        logic       stalled_prev = 1'b0;
        logic [3:0] prev_data = 4'h0;
        for (int i = 0; i < ncyc; i++) begin
            step();
            out_ready = rdy_pat[i % 8];
            start     = (i == spur_at);
            len       = (i == spur_at) ? 8'd1 : len;
            if (push_period != 0 && (i % push_period) == push_period - 1 &&
                (i / push_period) < push_n) begin
                push(push_base + 4'(i / push_period));
            end
            #1;
            if (stalled_prev) begin
                check("hold_valid", out_valid, 1'b1);
                check("hold_data", out_data, prev_data);
            end
            check("ren_when_empty", r_en & empty, 1'b0);
            if (r_en) ren_cnt++;
            if (out_valid && out_ready && n_got < 16) begin
                got[n_got] = out_data;
                n_got++;
                last_xfer = i;
            end
            check("credit_limit", ((ren_cnt - n_got) <= 2) ? 1 : 0, 1);
            if (done) begin
                done_cnt++;
                done_at = i;
            end
            stalled_prev = out_valid && !out_ready;
            prev_data    = out_data;
        end
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; len = 8'd0; abort = 1'b0; out_ready = 1'b0;
        clr_mon();
        #3;
        check("rst_r_en", r_en, 1'b0);
        check("rst_valid", out_valid, 1'b0);
        check("rst_data", out_data, 4'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_count", count, 8'd0);
        #9 rst_n = 1'b1;

        // Basic burst, full throughput
        for (int k = 1; k <= 4; k++) push(4'(k));
        step(); start = 1'b1; len = 8'd4; out_ready = 1'b1; #1;
        check("b_idle_ren", r_en, 1'b0);
        step(); start = 1'b0; #1;               // C0
        check("b_c0_ren", r_en, 1'b1);
        check("b_c0_busy", busy, 1'b1);
        check("b_c0_valid", out_valid, 1'b0);
        step(); #1;                             // C1
        check("b_c1_ren", r_en, 1'b1);
        check("b_c1_valid", out_valid, 1'b0);
        step(); #1;                             // C2
        check("b_c2_ren", r_en, 1'b1);
        check("b_c2_valid", out_valid, 1'b1);
        check("b_c2_data", out_data, 4'h1);
        step(); #1;                             // C3
        check("b_c3_ren", r_en, 1'b1);
        check("b_c3_data", out_data, 4'h2);
        check("b_c3_count", count, 8'd1);
        step(); #1;                             // C4
        check("b_c4_ren", r_en, 1'b0);
        check("b_c4_data", out_data, 4'h3);
        check("b_c4_busy", busy, 1'b1);
        step(); #1;                             // C5
        check("b_c5_data", out_data, 4'h4);
        check("b_c5_count", count, 8'd3);
        check("b_c5_done", done, 1'b0);
        step(); #1;                             // C6
        check("b_c6_done", done, 1'b1);
        check("b_c6_count", count, 8'd4);
        check("b_c6_valid", out_valid, 1'b0);
        check("b_c6_busy", busy, 1'b0);
        step(); #1;
        check("b_c7_done", done, 1'b0);

        // Backpressure, ready pattern 1,0,0,1,1,0,1,1
        for (int k = 1; k <= 4; k++) push(4'(k));
        clr_mon();
        step(); start = 1'b1; len = 8'd4; out_ready = 1'b0; #1;
        run(30, 8'b1101_1001, -1, 0, 0, 4'h0);
        check("bp_words", n_got, 4);
        for (int k = 0; k < 4; k++) check("bp_order", got[k], 4'(k + 1));
        check("bp_done_cnt", done_cnt, 1);
        check("bp_count", count, 8'd4);
        check("bp_reads", ren_cnt, 4);

        // Starved FIFO: 5,6,7 arrive one every 3 cycles
        clr_mon();
        step(); start = 1'b1; len = 8'd3; out_ready = 1'b1; #1;
        check("st_empty_ren", r_en, 1'b0);
        run(20, 8'hFF, -1, 3, 3, 4'h5);
        check("st_words", n_got, 3);
        for (int k = 0; k < 3; k++) check("st_order", got[k], 4'(k + 5));
        check("st_reads", ren_cnt, 3);
        check("st_done_cnt", done_cnt, 1);
        check("st_done_after_last", done_at, last_xfer + 1);

        // Zero length
        step(); start = 1'b1; len = 8'd0; #1;
        check("z_ren", r_en, 1'b0);
        step(); start = 1'b0; #1;
        check("z_done", done, 1'b1);
        check("z_count", count, 8'd0);
        check("z_ren2", r_en, 1'b0);
        check("z_busy", busy, 1'b0);
        step(); #1;
        check("z_done_off", done, 1'b0);

        // Start pulsed during RUN is ignored
        for (int k = 1; k <= 3; k++) push(4'(k));
        clr_mon();
        step(); start = 1'b1; len = 8'd3; out_ready = 1'b1; #1;
        len = 8'd3;
        run(20, 8'hFF, 1, 0, 0, 4'h0);
        check("bs_words", n_got, 3);
        check("bs_done_cnt", done_cnt, 1);
        check("bs_count", count, 8'd3);
        check("bs_last", got[2], 4'h3);

        // Abort after two words delivered
        for (int k = 1; k <= 4; k++) push(4'(k));
        step(); start = 1'b1; len = 8'd4; out_ready = 1'b1; #1;
        step(); start = 1'b0; #1;               // C0
        step(); #1;                             // C1
        step(); #1;                             // C2
        check("a_w1", out_data, 4'h1);
        step(); #1;                             // C3
        check("a_w2", out_data, 4'h2);
        step(); out_ready = 1'b0; abort = 1'b1; #1;  // C4
        check("a_c4_ren", r_en, 1'b0);
        check("a_c4_count", count, 8'd2);
        step(); abort = 1'b0; out_ready = 1'b1; #1;
        check("a_valid", out_valid, 1'b0);
        check("a_busy", busy, 1'b0);
        check("a_done", done, 1'b0);
        check("a_count", count, 8'd2);
        check("a_ren", r_en, 1'b0);
        step(); #1;
        check("a_done2", done, 1'b0);
        check("a_fifo_drained", empty, 1'b1);

        // Reset mid-burst with the buffer full
        for (int k = 1; k <= 4; k++) push(4'(k));
        step(); start = 1'b1; len = 8'd4; out_ready = 1'b0; #1;
        step(); start = 1'b0; #1;               // C0
        step(); #1;                             // C1
        step(); #1;                             // C2
        check("r_c2_ren", r_en, 1'b0);
        step(); #1;                             // C3
        check("r_full_valid", out_valid, 1'b1);
        check("r_full_data", out_data, 4'h1);
        rst_n = 1'b0; fifo_flush = 1'b1; #1;
        check("r_valid", out_valid, 1'b0);
        check("r_data", out_data, 4'h0);
        check("r_ren", r_en, 1'b0);
        check("r_busy", busy, 1'b0);
        check("r_done", done, 1'b0);
        check("r_count", count, 8'd0);
        step(); rst_n = 1'b1; fifo_flush = 1'b0;
        push(4'h9); push(4'hA);
        start = 1'b1; len = 8'd2; out_ready = 1'b1; #1;
        clr_mon();
        run(15, 8'hFF, -1, 0, 0, 4'h0);
        check("rr_words", n_got, 2);
        check("rr_w0", got[0], 4'h9);
        check("rr_w1", got[1], 4'hA);
        check("rr_count", count, 8'd2);
        check("rr_done_cnt", done_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
